multimem: RTL and testbench
===========================

MULTIMEM -- requirements
Module: multimem

Interface
REQ-001 Parameter PIXEL_WIDTH, default 64, display width in pixels.
REQ-002 Parameter PIXEL_HEIGHT, default 32, display height in pixels.
REQ-003 Parameter BYTES_PER_PIXEL, default 2, bytes stored per pixel.
REQ-004 Derived: AW = clog2(PIXEL_HEIGHT*PIXEL_WIDTH*BYTES_PER_PIXEL), which is 12 at defaults; LANES = 2*BYTES_PER_PIXEL, which is 4 at defaults; BW = AW - clog2(LANES), which is 10 at defaults.
REQ-005 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-006 ClockA  input  1  the single clock for both ports; all logic on its rising edge.
REQ-007 ResetA  input  1  synchronous active-high reset, write port.
REQ-008 ResetB  input  1  synchronous active-high reset, read port.
REQ-009 DataInA  input  8  write byte.
REQ-010 AddressA  input  AW  byte write address.
REQ-011 ClockEnA  input  1  write-port enable.
REQ-012 WrA  input  1  write strobe.
REQ-013 AddressB  input  BW  word read address; one word is LANES bytes.
REQ-014 ClockEnB  input  1  read-port enable.
REQ-015 QB  output  LANES*8  registered read word; 32 bits at defaults.

Function
REQ-016 Storage SHALL be 2^AW bytes, organised as LANES byte-wide banks of 2^BW entries each.
REQ-017 Bank select SHALL be AddressA[clog2(LANES)-1:0], and the bank entry SHALL be AddressA[AW-1:clog2(LANES)].
REQ-018 A write SHALL occur on a rising edge with ClockEnA=1, WrA=1 and ResetA=0; DataInA is then stored at AddressA.
REQ-019 ClockEnA=0 or WrA=0 SHALL leave memory unchanged.
REQ-020 On a rising edge with ClockEnB=1 and ResetB=0, QB SHALL load word AddressB, giving a read latency of 1 cycle.
REQ-021 In QB, byte lane k, bits [8k+7:8k], SHALL hold the byte at byte address {AddressB, k}; byte address LANES*b+LANES-1 therefore maps to the top lane.
REQ-022 When ClockEnB=0, QB SHALL hold its previous value.
REQ-023 A read and a write to the same byte in the same cycle SHALL be read-first: QB returns the old byte, and the new byte is visible on the next read.
REQ-024 Reads and writes to different addresses in the same cycle SHALL both complete with no interaction.
REQ-025 All address arithmetic SHALL be unsigned, with no wrap or clamp; the full AW range is valid.
REQ-026 Memory contents SHALL be zero at configuration or simulation start.

Reset
REQ-027 ResetB=1 SHALL clear QB to 0 at the next rising edge, overriding ClockEnB.
REQ-028 ResetA=1 SHALL suppress any write that cycle.
REQ-029 Neither reset SHALL alter memory contents.
REQ-030 Asserting a reset mid-sequence SHALL affect only its own port; the other port continues normally.
REQ-031 Reset deassertion SHALL require no recovery cycles.

Structure
REQ-032 Derived widths (AW, BW, LANES) SHALL be localparams computed from the module parameters; the shared display-parameter header supplies the defaults.
REQ-033 One sub-module, multimem_bank, SHALL be instantiated LANES times.
REQ-034 multimem_bank SHALL be a byte-wide simple dual-port RAM with a write-enabled write port and a registered, enable-gated, reset-clearable read port, inferable as block RAM.
REQ-035 The top level SHALL contain only lane decode and QB concatenation.

Verification
REQ-036 Scenario: write 0x41 at 0xFFF, then 0x42 at 0xFFE; read AddressB=0x3FF -> one cycle later QB[31:24]=0x41, QB[23:16]=0x42, QB[15:0]=0x0000.
REQ-037 Scenario: overwrite 0xFFF with 0x43, then read 0x3FF -> QB[31:24]=0x43, QB[23:16]=0x42 unchanged.
REQ-038 Scenario (continues from REQ-037): write 0x44 at 0xFFF; then, in the same cycle, write 0x45 at 0xFFE and read 0x3FF -> QB[23:16]=0x42 (old); the next read gives 0x45; the next cycle writes 0x46 at 0xFFE -> the following read gives 0x46.
REQ-039 Scenario (continues from REQ-038): write 0x5A at 0x7FF and 0x59 at 0x7FE; read 0x1FF -> QB[31:16]=0x5A59; a read of 0x3FF still returns QB[31:24]=0x44.
REQ-040 Scenario (continues from REQ-039): drop ClockEnB and change AddressB -> QB holds; pulse ResetB -> QB=0 next edge.
REQ-041 Scenario: pulse ResetA together with WrA=1 -> memory unchanged; memory is also unchanged when WrA=1 with ClockEnA=0.

Source files
------------

// File: rtl/multimem_pkg.sv
// Shared display geometry defaults and address-width helpers for the multimem frame store.
package multimem_pkg;

    localparam int DEFAULT_PIXEL_WIDTH     = 64;
    localparam int DEFAULT_PIXEL_HEIGHT    = 32;
    localparam int DEFAULT_BYTES_PER_PIXEL = 2;

    typedef logic [7:0] byte_t;

    function automatic int byte_addr_width(input int width, input int height, input int bpp);
        return $clog2(width * height * bpp);
    endfunction

    // A read word spans two pixels' worth of bytes.
    function automatic int lane_count(input int bpp);
        return 2 * bpp;
    endfunction

endpackage

// File: rtl/multimem_bank.sv
// Byte-wide simple dual-port RAM: one write port, one registered read port
// with enable and synchronous clear. Read-during-write returns the old byte.
module multimem_bank
    import multimem_pkg::*;
#(
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  byte_t                 wr_data,
    input  logic                  rd_en,
    input  logic                  rd_rst,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output byte_t                 rd_data
);

    byte_t mem [2**DEPTH_BITS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Clearing the output register never touches the array contents.
    always_ff @(posedge clk) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/multimem.sv
// Frame-store memory: byte-wide writes, LANES-byte-wide registered reads.
// Low address bits pick the bank; lane k of QB holds byte {AddressB, k}.
module multimem
    import multimem_pkg::*;
#(
    parameter  int PIXEL_WIDTH     = DEFAULT_PIXEL_WIDTH,
    parameter  int PIXEL_HEIGHT    = DEFAULT_PIXEL_HEIGHT,
    parameter  int BYTES_PER_PIXEL = DEFAULT_BYTES_PER_PIXEL,
    localparam int AW              = byte_addr_width(PIXEL_WIDTH, PIXEL_HEIGHT, BYTES_PER_PIXEL),
    localparam int LANES           = lane_count(BYTES_PER_PIXEL),
    localparam int LB              = $clog2(LANES),
    localparam int BW              = AW - LB
) (
    input  logic               ClockA,
    input  logic               ResetA,
    input  logic               ResetB,
    input  logic [7:0]         DataInA,
    input  logic [AW-1:0]      AddressA,
    input  logic               ClockEnA,
    input  logic               WrA,
    input  logic [BW-1:0]      AddressB,
    input  logic               ClockEnB,
    output logic [LANES*8-1:0] QB
);

    logic          wr_ok;
    logic [LB-1:0] wr_lane;
    logic [BW-1:0] wr_entry;

    assign wr_ok    = ClockEnA & WrA & ~ResetA;
    assign wr_lane  = AddressA[LB-1:0];
    assign wr_entry = AddressA[AW-1:LB];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        multimem_bank #(
            .DEPTH_BITS(BW)
        ) u_bank (
            .clk    (ClockA),
            .wr_en  (wr_ok && (wr_lane == LB'(k))),
            .wr_addr(wr_entry),
            .wr_data(DataInA),
            .rd_en  (ClockEnB),
            .rd_rst (ResetB),
            .rd_addr(AddressB),
            .rd_data(QB[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_multimem.sv
// Self-checking bench for multimem: a byte-array model predicts every QB word,
// expectations are queued when a cycle is driven and popped after the edge.
module tb_multimem;

    localparam int AW    = 12;
    localparam int LANES = 4;
    localparam int BW    = 10;
    localparam int QW    = LANES * 8;

    logic          clk;
    logic          ResetA;
    logic          ResetB;
    logic [7:0]    DataInA;
    logic [AW-1:0] AddressA;
    logic          ClockEnA;
    logic          WrA;
    logic [BW-1:0] AddressB;
    logic          ClockEnB;
    logic [QW-1:0] QB;

    logic [7:0]    mem_model [2**AW];
    logic [QW-1:0] q_model;
    logic [QW-1:0] exp_q [$];
    logic [QW-1:0] want;
    int            n_checks;
    int            n_fail;

    multimem dut (
        .ClockA  (clk),
        .ResetA  (ResetA),
        .ResetB  (ResetB),
        .DataInA (DataInA),
        .AddressA(AddressA),
        .ClockEnA(ClockEnA),
        .WrA     (WrA),
        .AddressB(AddressB),
        .ClockEnB(ClockEnB),
        .QB      (QB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, queue the predicted QB, update the model, then step past the edge.
    task automatic drive_cycle(input logic cea, input logic wa, input logic [AW-1:0] aa,
                               input logic [7:0] da, input logic ra,
                               input logic ceb, input logic [BW-1:0] ab, input logic rb);
        ClockEnA = cea;
        WrA      = wa;
        AddressA = aa;
        DataInA  = da;
        ResetA   = ra;
        ClockEnB = ceb;
        AddressB = ab;
        ResetB   = rb;
        if (rb) begin
            q_model = '0;
        end else if (ceb) begin
            for (int k = 0; k < LANES; k++) begin
                q_model[8*k +: 8] = mem_model[{ab, 2'(k)}];
            end
        end
        exp_q.push_back(q_model);
        if (cea && wa && !ra) begin
            mem_model[aa] = da;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [AW-1:0] aa, input logic [7:0] da);
        drive_cycle(1'b1, 1'b1, aa, da, 1'b0, 1'b0, '0, 1'b0);
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b1, '0, 1'b1);
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b1, 10'h3FF, 1'b1);
        want = exp_q.pop_front();
        void'(exp_q.pop_front());
        n_checks++;
        if (QB !== '0 || want !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_qb: QB=%h expected 00000000", QB);
        end
        for (int b = 0; b < 3; b++) begin
            drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, BW'(b * 341), 1'b0);
            want = exp_q.pop_front();
            n_checks++;
            if (QB !== want) begin
                n_fail++;
                $display("[TB] FAIL init_zero word %0d: QB=%h expected %h", b * 341, QB, want);
            end
        end
    endtask

    task automatic test_top_word();
        write_byte(12'hFFF, 8'h41);
        write_byte(12'hFFE, 8'h42);
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h4142_0000) begin
            n_fail++;
            $display("[TB] FAIL top_word: QB=%h expected 41420000", QB);
        end
    endtask

    task automatic test_overwrite();
        write_byte(12'hFFF, 8'h43);
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h4342_0000) begin
            n_fail++;
            $display("[TB] FAIL overwrite: QB=%h expected 43420000", QB);
        end
    endtask

    task automatic test_read_first();
        write_byte(12'hFFF, 8'h44);
        drive_cycle(1'b1, 1'b1, 12'hFFE, 8'h45, 1'b0, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h4442_0000) begin
            n_fail++;
            $display("[TB] FAIL read_first_old: QB=%h expected 44420000", QB);
        end
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h4445_0000) begin
            n_fail++;
            $display("[TB] FAIL read_first_new: QB=%h expected 44450000", QB);
        end
        write_byte(12'hFFE, 8'h46);
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h4446_0000) begin
            n_fail++;
            $display("[TB] FAIL rewrite_46: QB=%h expected 44460000", QB);
        end
    endtask

    task automatic test_other_word();
        write_byte(12'h7FF, 8'h5A);
        write_byte(12'h7FE, 8'h59);
        drive_cycle(1'b1, 1'b1, 12'h000, 8'h11, 1'b0, 1'b1, 10'h1FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB[31:16] !== 16'h5A59) begin
            n_fail++;
            $display("[TB] FAIL word_1ff: QB=%h expected %h", QB, want);
        end
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB[31:24] !== 8'h44) begin
            n_fail++;
            $display("[TB] FAIL word_3ff_again: QB=%h expected %h", QB, want);
        end
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h000, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h0000_0011) begin
            n_fail++;
            $display("[TB] FAIL word_000: QB=%h expected 00000011", QB);
        end
    endtask

    task automatic test_hold_and_reset();
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, BW'(i * 7 + 1), 1'b0);
            want = exp_q.pop_front();
            n_checks++;
            if (QB !== want || QB !== 32'h4446_0000) begin
                n_fail++;
                $display("[TB] FAIL hold_%0d: QB=%h expected 44460000", i, QB);
            end
        end
        drive_cycle(1'b1, 1'b1, 12'h004, 8'h77, 1'b0, 1'b1, 10'h3FF, 1'b1);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== '0) begin
            n_fail++;
            $display("[TB] FAIL resetb_clear: QB=%h expected 00000000", QB);
        end
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h001, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h0000_0077) begin
            n_fail++;
            $display("[TB] FAIL write_during_resetb: QB=%h expected 00000077", QB);
        end
    endtask

    task automatic test_write_suppress();
        drive_cycle(1'b1, 1'b1, 12'hFFF, 8'h99, 1'b1, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h4446_0000) begin
            n_fail++;
            $display("[TB] FAIL read_during_reseta: QB=%h expected 44460000", QB);
        end
        drive_cycle(1'b0, 1'b1, 12'hFFF, 8'h98, 1'b0, 1'b0, '0, 1'b0);
        void'(exp_q.pop_front());
        drive_cycle(1'b1, 1'b0, 12'hFFE, 8'h97, 1'b0, 1'b0, '0, 1'b0);
        void'(exp_q.pop_front());
        drive_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
        want = exp_q.pop_front();
        n_checks++;
        if (QB !== want || QB !== 32'h4446_0000) begin
            n_fail++;
            $display("[TB] FAIL write_suppressed: QB=%h expected 44460000", QB);
        end
    endtask

    task automatic test_random_traffic();
        logic [AW-1:0] wa;
        logic [BW-1:0] rb;
        for (int i = 0; i < 200; i++) begin
            wa = AW'($urandom_range(0, 2**AW - 1));
            rb = (i % 2 == 0) ? wa[AW-1:2] : BW'($urandom_range(0, 2**BW - 1));
            drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), wa,
                        8'($urandom), 1'($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 4) != 0), rb, 1'($urandom_range(0, 9) == 0));
            want = exp_q.pop_front();
            n_checks++;
            if (QB !== want) begin
                n_fail++;
                $display("[TB] FAIL random_%0d: QB=%h expected %h", i, QB, want);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        q_model  = '0;
        for (int i = 0; i < 2**AW; i++) begin
            mem_model[i] = 8'h00;
        end
        ClockEnA = 1'b0;
        WrA      = 1'b0;
        AddressA = '0;
        DataInA  = '0;
        ResetA   = 1'b1;
        ClockEnB = 1'b0;
        AddressB = '0;
        ResetB   = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_top_word();
        test_overwrite();
        test_read_first();
        test_other_word();
        test_hold_and_reset();
        test_write_suppress();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
